// File: rtl/keypad_matrix_model.sv
// Behavioural 3x3 key matrix with press/release contact bounce, driven by "press key K for N ticks" commands.
// Optional press_count output enabled by defining KEYPAD_MODEL_PRESS_COUNT_EN.
module keypad_matrix_model #(
   parameter int unsigned TICK_DIV      = 50000,
   parameter int unsigned BOUNCE_EDGES  = 4,
   parameter int unsigned BOUNCE_CYCLES = 2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  column,
   output logic [2:0]  row,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_key,
   input  logic [15:0] cmd_hold,
   output logic        cmd_err,
   output logic        busy,
   output logic        done,
   output logic        contact
`ifdef KEYPAD_MODEL_PRESS_COUNT_EN
   ,
   output logic [7:0]  press_count
`endif
);

   localparam int unsigned BC_W = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
   localparam int unsigned EC_W = (BOUNCE_EDGES > 0) ? $clog2(BOUNCE_EDGES + 1) : 1;
   localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(BOUNCE_CYCLES - 1);
   localparam logic [EC_W-1:0] EC_LAST = EC_W'((BOUNCE_EDGES > 0) ? BOUNCE_EDGES - 1 : 0);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, PRESS_B, HOLD, REL_B} state_t;

   state_t            state_q, state_d;
   logic              contact_q, contact_d;
   logic [BC_W-1:0]   bcnt_q, bcnt_d;
   logic [EC_W-1:0]   ecnt_q, ecnt_d;
   logic [PS_W-1:0]   psc_q, psc_d;
   logic [15:0]       hold_q, hold_d;
   logic [3:0]        key_q, key_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        key_row, key_col;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         contact_q <= 1'b0;
         bcnt_q    <= '0;
         ecnt_q    <= '0;
         psc_q     <= '0;
         hold_q    <= 16'd0;
         key_q     <= 4'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         contact_q <= contact_d;
         bcnt_q    <= bcnt_d;
         ecnt_q    <= ecnt_d;
         psc_q     <= psc_d;
         hold_q    <= hold_d;
         key_q     <= key_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Command handshake, bounce sequencing and hold-tick countdown.
   always_comb begin
      state_d   = state_q;
      contact_d = contact_q;
      bcnt_d    = bcnt_q;
      ecnt_d    = ecnt_q;
      psc_d     = psc_q;
      hold_d    = hold_q;
      key_d     = key_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            contact_d = 1'b0;
            if (cmd_valid) begin
               if (cmd_key <= 4'd8) begin
                  state_d   = PRESS_B;
                  key_d     = cmd_key;
                  hold_d    = (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
                  contact_d = 1'b1;
                  bcnt_d    = '0;
                  ecnt_d    = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         PRESS_B: begin
            if (BOUNCE_EDGES == 0) begin
               contact_d = 1'b1;
               psc_d     = '0;
               state_d   = HOLD;
            end else if (bcnt_q == BC_LAST) begin
               bcnt_d = '0;
               if (ecnt_q == EC_LAST) begin
                  contact_d = 1'b1;
                  psc_d     = '0;
                  state_d   = HOLD;
               end else begin
                  contact_d = ~contact_q;
                  ecnt_d    = ecnt_q + EC_W'(1);
               end
            end else begin
               bcnt_d = bcnt_q + BC_W'(1);
            end
         end
         HOLD: begin
            contact_d = 1'b1;
            if (psc_q == PS_LAST) begin
               psc_d  = '0;
               hold_d = hold_q - 16'd1;
               if (hold_q == 16'd1) begin
                  contact_d = 1'b0;
                  bcnt_d    = '0;
                  ecnt_d    = '0;
                  state_d   = REL_B;
               end
            end else begin
               psc_d = psc_q + PS_W'(1);
            end
         end
         REL_B: begin
            if (BOUNCE_EDGES == 0) begin
               contact_d = 1'b0;
               done_d    = 1'b1;
               state_d   = IDLE;
            end else if (bcnt_q == BC_LAST) begin
               bcnt_d = '0;
               if (ecnt_q == EC_LAST) begin
                  contact_d = 1'b0;
                  done_d    = 1'b1;
                  state_d   = IDLE;
               end else begin
                  contact_d = ~contact_q;
                  ecnt_d    = ecnt_q + EC_W'(1);
               end
            end else begin
               bcnt_d = bcnt_q + BC_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Key code to matrix coordinate.
   always_comb begin
      key_row = 2'd0;
      key_col = 2'd0;
      case (key_q)
         4'd1: key_col = 2'd1;
         4'd2: key_col = 2'd2;
         4'd3: key_row = 2'd1;
         4'd4: begin key_row = 2'd1; key_col = 2'd1; end
         4'd5: begin key_row = 2'd1; key_col = 2'd2; end
         4'd6: key_row = 2'd2;
         4'd7: begin key_row = 2'd2; key_col = 2'd1; end
         4'd8: begin key_row = 2'd2; key_col = 2'd2; end
         default: ;
      endcase
   end

   // Passive matrix: the closed key connects its column drive straight to its row.
   always_comb begin
      row = 3'b111;
      if (contact_q && !column[key_col]) row[key_row] = 1'b0;
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign cmd_err   = err_q;
   assign contact   = contact_q;

`ifdef KEYPAD_MODEL_PRESS_COUNT_EN
   logic [7:0] pcnt_q, pcnt_d;

   always_comb begin
      pcnt_d = pcnt_q;
      if (state_q == IDLE && cmd_valid && cmd_key <= 4'd8) pcnt_d = pcnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pcnt_q <= 8'd0;
      else        pcnt_q <= pcnt_d;
   end

   assign press_count = pcnt_q;
`endif

endmodule

// File: tb/tb_keypad_matrix_model.sv
// Two model instances (clean edges and bouncing edges) share one randomized stimulus stream and are
// compared every cycle against a timeline model built from the press/hold/release durations.
module tb_keypad_matrix_model;
   localparam int unsigned TD0 = 4, BE0 = 0, BC0 = 1;
   localparam int unsigned TD1 = 3, BE1 = 4, BC1 = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  column;
   logic        cmd_valid;
   logic [3:0]  cmd_key;
   logic [15:0] cmd_hold;
   logic [1:0][2:0] row_v;
   logic [1:0]  ready_v, err_v, busy_v, done_v, contact_v;
`ifdef KEYPAD_MODEL_PRESS_COUNT_EN
   logic [1:0][7:0] pc_v;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   keypad_matrix_model #(.TICK_DIV(TD0), .BOUNCE_EDGES(BE0), .BOUNCE_CYCLES(BC0)) u_clean (
      .clk(clk), .reset(reset), .column(column), .row(row_v[0]),
      .cmd_valid(cmd_valid), .cmd_ready(ready_v[0]), .cmd_key(cmd_key), .cmd_hold(cmd_hold),
      .cmd_err(err_v[0]), .busy(busy_v[0]), .done(done_v[0]), .contact(contact_v[0])
`ifdef KEYPAD_MODEL_PRESS_COUNT_EN
      , .press_count(pc_v[0])
`endif
   );

   keypad_matrix_model #(.TICK_DIV(TD1), .BOUNCE_EDGES(BE1), .BOUNCE_CYCLES(BC1)) u_bnc (
      .clk(clk), .reset(reset), .column(column), .row(row_v[1]),
      .cmd_valid(cmd_valid), .cmd_ready(ready_v[1]), .cmd_key(cmd_key), .cmd_hold(cmd_hold),
      .cmd_err(err_v[1]), .busy(busy_v[1]), .done(done_v[1]), .contact(contact_v[1])
`ifdef KEYPAD_MODEL_PRESS_COUNT_EN
      , .press_count(pc_v[1])
`endif
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp_v);
      end
   endtask

   // Reference model: an operation is a timeline of k cycles since the accepting edge.
   bit act [2];
   int k [2];
   int hld [2];
   int key_m [2];
   bit errp [2];
   int pcnt [2];

   function automatic int phase_len(input int i);
      int e, b;
      e = (i == 1) ? BE1 : BE0;
      b = (i == 1) ? BC1 : BC0;
      return (e == 0) ? 1 : e * b;
   endfunction

   function automatic int op_len(input int i);
      int t;
      t = (i == 1) ? TD1 : TD0;
      return 2 * phase_len(i) + hld[i] * t;
   endfunction

   function automatic logic exp_contact(input int i, input int kk);
      int e, b, t, p, r;
      e = (i == 1) ? BE1 : BE0;
      b = (i == 1) ? BC1 : BC0;
      t = (i == 1) ? TD1 : TD0;
      p = phase_len(i);
      r = p + hld[i] * t;
      if (kk < p) return (e == 0) ? 1'b1 : (((kk / b) % 2) == 0);
      if (kk < r) return 1'b1;
      if (kk < r + p) return (e == 0) ? 1'b0 : ((((kk - r) / b) % 2) == 1);
      return 1'b0;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            logic e_busy, e_ready, e_done, e_c;
            logic [2:0] e_row;
            if (!reset) begin
               act[i]  = 1'b0;
               errp[i] = 1'b0;
               pcnt[i] = 0;
            end
            e_done = 1'b0;
            if (act[i] && k[i] < op_len(i)) begin
               e_busy = 1'b1; e_ready = 1'b0; e_c = exp_contact(i, k[i]);
            end else begin
               e_busy = 1'b0; e_ready = 1'b1; e_c = 1'b0; e_done = act[i];
            end
            e_row = 3'b111;
            if (e_c && !column[key_m[i] % 3]) e_row[key_m[i] / 3] = 1'b0;
            chk($sformatf("row[%0d]", i), 32'(row_v[i]), 32'(e_row));
            chk($sformatf("contact[%0d]", i), 32'(contact_v[i]), 32'(e_c));
            chk($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(e_busy));
            chk($sformatf("cmd_ready[%0d]", i), 32'(ready_v[i]), 32'(e_ready));
            chk($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(e_done));
            chk($sformatf("cmd_err[%0d]", i), 32'(err_v[i]), 32'(errp[i]));
`ifdef KEYPAD_MODEL_PRESS_COUNT_EN
            chk($sformatf("press_count[%0d]", i), 32'(pc_v[i]), 32'(pcnt[i] % 256));
`endif
            if (act[i]) begin
               if (k[i] >= op_len(i)) act[i] = 1'b0;
               else k[i]++;
            end
            errp[i] = 1'b0;
            if (reset && e_ready && cmd_valid) begin
               if (cmd_key <= 4'd8) begin
                  act[i]   = 1'b1;
                  k[i]     = 0;
                  hld[i]   = (cmd_hold == 16'd0) ? 1 : int'(cmd_hold);
                  key_m[i] = int'(cmd_key);
                  pcnt[i]  = (pcnt[i] + 1) % 256;
               end else begin
                  errp[i] = 1'b1;
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy_v != 2'b00 && n < 300) begin
         cyc();
         n++;
      end
      chk("wait_idle", 32'(busy_v), 32'd0);
      cyc();
   endtask

   task automatic offer(input logic [3:0] key, input logic [15:0] hold);
      cmd_key   = key;
      cmd_hold  = hold;
      cmd_valid = 1'b1;
      cyc();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] pats [6];
      int lows, dones, busys, nonidle, edges_seen;
      logic prev;
      pats = '{3'b110, 3'b101, 3'b011, 3'b111, 3'b100, 3'b000};
      column = 3'b110; cmd_valid = 1'b0; cmd_key = 4'd0; cmd_hold = 16'd0;

      // Reset state.
      repeat (3) cyc();
      chk("rst_row", 32'(row_v[0]), 32'h7);
      chk("rst_ready", 32'(ready_v), 32'h3);
      chk("rst_busy", 32'(busy_v), 32'h0);
      chk("rst_contact", 32'(contact_v), 32'h0);
      @(posedge clk); #2 reset = 1'b1;
      cyc();

      // Clean press on the TICK_DIV=4, no-bounce instance: 1 settle cycle plus 3*4 hold cycles closed.
      wait_idle();
      column = 3'b101;
      offer(4'd4, 16'd3);
      lows = 0; dones = 0;
      for (int n = 0; n < 40; n++) begin
         if (row_v[0] == 3'b101) lows++;
         if (done_v[0]) dones++;
         cyc();
      end
      chk("clean_low_cycles", 32'(lows), 32'(1 + 3 * 4));
      chk("clean_done_count", 32'(dones), 32'd1);
      chk("clean_row_after", 32'(row_v[0]), 32'h7);

      // Same key with its column high: row never moves.
      wait_idle();
      column = 3'b110;
      offer(4'd4, 16'd2);
      nonidle = 0; busys = 0;
      for (int n = 0; n < 30; n++) begin
         if (row_v[0] != 3'b111) nonidle++;
         if (busy_v[0]) busys++;
         cyc();
      end
      chk("other_col_row", 32'(nonidle), 32'd0);
      chk("other_col_busy", 32'(busys), 32'(1 + 2 * 4 + 1));

      // Bounce press on key 0: 5 row edges into the press, 5 out of the release.
      wait_idle();
      column = 3'b110;
      offer(4'd0, 16'd1);
      prev = 1'b1; edges_seen = 0; dones = 0;
      for (int n = 0; n < 30; n++) begin
         if (row_v[1][0] != prev) edges_seen++;
         prev = row_v[1][0];
         if (done_v[1]) dones++;
         cyc();
      end
      chk("bounce_row_edges", 32'(edges_seen), 32'd10);
      chk("bounce_done_count", 32'(dones), 32'd1);
      chk("bounce_row_after", 32'(row_v[1]), 32'h7);

      // Illegal key.
      wait_idle();
      offer(4'd9, 16'd1);
      chk("illegal_err", 32'(err_v), 32'h3);
      chk("illegal_busy", 32'(busy_v), 32'h0);
      cyc();
      chk("illegal_err_clear", 32'(err_v), 32'h0);

      // Command during HOLD is ignored.
      wait_idle();
      column = 3'b011;
      offer(4'd2, 16'd2);
      cyc(); cyc();
      offer(4'd5, 16'd1);
      busys = 0; dones = 0;
      for (int n = 0; n < 30; n++) begin
         if (busy_v[0]) busys++;
         if (done_v[0]) dones++;
         cyc();
      end
      chk("ignored_busy_cycles", 32'(busys), 32'd7);
      chk("ignored_done_count", 32'(dones), 32'd1);

      // Reset during HOLD of key 8.
      wait_idle();
      column = 3'b011;
      offer(4'd8, 16'd5);
      cyc(); cyc(); cyc();
      chk("midrst_row_before", 32'(row_v[0]), 32'h3);
      #1 reset = 1'b0;
      #1;
      chk("midrst_row_async", 32'(row_v[0]), 32'h7);
      chk("midrst_done", 32'(done_v), 32'h0);
      chk("midrst_busy", 32'(busy_v), 32'h0);
      @(posedge clk); #2 reset = 1'b1;
      offer(4'd8, 16'd1);
      chk("midrst_next_busy", 32'(busy_v[0]), 32'd1);
      chk("midrst_next_row", 32'(row_v[0]), 32'h3);

      // Randomized traffic.
      wait_idle();
      for (int n = 0; n < 3000; n++) begin
         column    = pats[$urandom_range(0, 5)];
         cmd_valid = ($urandom_range(0, 9) < 3);
         cmd_key   = 4'($urandom_range(0, 10));
         cmd_hold  = 16'($urandom_range(0, 3));
         cyc();
      end
      cmd_valid = 1'b0;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
